mul_pipe: RTL and testbench

Parametrised, pipelined integer multiplier for the M-extension execute path. It succeeds the fixed 32x32 combinational signed multiplier. It adds:
- Generic XLEN.
- Configurable pipeline depth.
- Per-op signedness (MUL/MULH/MULHSU/MULHU) with low/high result select.
- valid/ready handshake with backpressure, a tag passthrough and a flush.

The EX stage issues into it, and writeback consumes from it.

---
 rtl/mul_pipe.sv | 168 ++++++++++++++++
 tb/tb_mul_pipe.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_pipe.sv
// mul_pipe: pipelined XLEN x XLEN multiplier for the M-extension execute path.
// Handles MUL/MULH/MULHSU/MULHU with a valid/ready handshake, a tag sideband
// and a flush. Stage 0 captures the operands. The next stage holds the two
// partial products (b split into low and high halves) as a carry-save pair.
// The output stage does the final carry-propagate add and the half select.
// With STAGES=1 the whole product is formed combinationally and registered once.
module mul_pipe #(
  parameter int XLEN   = 32,
  parameter int STAGES = 3,
  parameter int TAG_W  = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [XLEN-1:0]  in_a,
  input  logic [XLEN-1:0]  in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  localparam int PW = 2 * XLEN;
  localparam int H  = XLEN / 2;

  // Product term a * b_lo, where b_lo = b[H-1:0] is always unsigned.
  // The arithmetic is done modulo 2^PW, so extending both terms to PW bits
  // is enough to make signed and unsigned cases come out exact.
  function automatic logic [PW-1:0] pp_low(input logic [XLEN-1:0] a,
                                           input logic [H-1:0] b_lo,
                                           input logic [1:0] op);
    logic [PW-1:0] a_w;
    a_w = {{XLEN{(op != 2'b11) & a[XLEN-1]}}, a};
    return a_w * {{(PW-H){1'b0}}, b_lo};
  endfunction

  // Product term a * b_hi * 2^H, where b_hi is the upper part of the
  // (possibly sign-extended) multiplier.
  function automatic logic [PW-1:0] pp_high(input logic [XLEN-1:0] a,
                                            input logic [XLEN-1:0] b,
                                            input logic [1:0] op);
    logic [PW-1:0] a_w;
    logic [PW-1:0] hi_w;
    a_w  = {{XLEN{(op != 2'b11) & a[XLEN-1]}}, a};
    hi_w = {{(PW-XLEN+H){~op[1] & b[XLEN-1]}}, b[XLEN-1:H]};
    return (a_w * hi_w) << H;
  endfunction

  // MUL returns the low half; every other op returns the high half.
  function automatic logic [XLEN-1:0] pick(input logic [PW-1:0] p,
                                           input logic [1:0] op);
    if (op == 2'b00) begin
      return p[XLEN-1:0];
    end else begin
      return p[PW-1:XLEN];
    end
  endfunction

  logic [STAGES-1:0] v_r;
  logic              adv_s;
  logic              acc_s;

  logic [PW-1:0]     fin_pl_s;
  logic [PW-1:0]     fin_ph_s;
  logic [1:0]        fin_op_s;
  logic [TAG_W-1:0]  fin_tag_s;
  logic              fin_v_s;

  assign adv_s     = !v_r[STAGES-1] || out_ready;
  assign in_ready  = adv_s && !flush;
  assign acc_s     = in_valid && in_ready;
  assign out_valid = v_r[STAGES-1];
  assign busy      = |v_r;

  // Stage valid bits: advance together; reset and flush kill everything.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      v_r <= '0;
    end else if (adv_s) begin
      v_r[0] <= acc_s;
      for (int i = 1; i < STAGES; i++) begin
        v_r[i] <= v_r[i-1];
      end
    end
  end

  if (STAGES == 1) begin : g_comb
    assign fin_pl_s  = pp_low(in_a, in_b[H-1:0], in_op);
    assign fin_ph_s  = pp_high(in_a, in_b, in_op);
    assign fin_op_s  = in_op;
    assign fin_tag_s = in_tag;
    assign fin_v_s   = acc_s;
  end else begin : g_pipe
    logic [XLEN-1:0]  a_r;
    logic [XLEN-1:0]  b_r;
    logic [1:0]       op0_r;
    logic [TAG_W-1:0] tag0_r;
    logic [PW-1:0]    pl_s;
    logic [PW-1:0]    ph_s;

    // Operand capture: only a real transfer loads new operands.
    always_ff @(posedge clk) begin
      if (acc_s) begin
        a_r    <= in_a;
        b_r    <= in_b;
        op0_r  <= in_op;
        tag0_r <= in_tag;
      end
    end

    assign pl_s = pp_low(a_r, b_r[H-1:0], op0_r);
    assign ph_s = pp_high(a_r, b_r, op0_r);

    if (STAGES == 2) begin : g_two
      assign fin_pl_s  = pl_s;
      assign fin_ph_s  = ph_s;
      assign fin_op_s  = op0_r;
      assign fin_tag_s = tag0_r;
      assign fin_v_s   = v_r[0];
    end else begin : g_deep
      localparam int M = STAGES - 2;
      logic [PW-1:0]    pl_r  [M];
      logic [PW-1:0]    ph_r  [M];
      logic [1:0]       opm_r [M];
      logic [TAG_W-1:0] tagm_r[M];

      // Carry-save pair shifts down the pipe whenever the pipe advances.
      always_ff @(posedge clk) begin
        if (adv_s) begin
          pl_r[0]   <= pl_s;
          ph_r[0]   <= ph_s;
          opm_r[0]  <= op0_r;
          tagm_r[0] <= tag0_r;
          for (int j = 1; j < M; j++) begin
            pl_r[j]   <= pl_r[j-1];
            ph_r[j]   <= ph_r[j-1];
            opm_r[j]  <= opm_r[j-1];
            tagm_r[j] <= tagm_r[j-1];
          end
        end
      end

      assign fin_pl_s  = pl_r[M-1];
      assign fin_ph_s  = ph_r[M-1];
      assign fin_op_s  = opm_r[M-1];
      assign fin_tag_s = tagm_r[M-1];
      assign fin_v_s   = v_r[STAGES-2];
    end
  end

  // Output stage: final add and half select; loads only when a valid op
  // moves in, so the result stays stable under backpressure.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_result <= '0;
      out_tag    <= '0;
    end else if (adv_s && fin_v_s && !flush) begin
      out_result <= pick(fin_pl_s + fin_ph_s, fin_op_s);
      out_tag    <= fin_tag_s;
    end
  end

endmodule

// File: tb/tb_mul_pipe.sv
// Directed bench for mul_pipe: three instances (32x3, 8x1, 64x4) share one
// stimulus bus; expected values are hand-computed tables plus a wide
// reference multiply for the random sweep.
module tb_mul_pipe;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [1:0]  in_op;
  logic [63:0] in_a, in_b;
  logic [4:0]  in_tag;

  logic        in_ready32, out_valid32, busy32;
  logic [31:0] out_result32;
  logic [4:0]  out_tag32;
  logic        in_ready8, out_valid8, busy8;
  logic [7:0]  out_result8;
  logic [4:0]  out_tag8;
  logic        in_ready64, out_valid64, busy64;
  logic [63:0] out_result64;
  logic [4:0]  out_tag64;

  int n_vec = 0;
  int n_bad = 0;

  logic [1:0]  op_t  [16];
  logic [63:0] a_t   [16];
  logic [63:0] b_t   [16];
  logic [4:0]  tag_t [16];
  logic [63:0] e8    [16];
  logic [63:0] e32   [16];
  logic [63:0] e64   [16];

  always #5 clk = ~clk;

  mul_pipe #(.XLEN(32), .STAGES(3), .TAG_W(5)) d32 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready32),
    .in_op(in_op), .in_a(in_a[31:0]), .in_b(in_b[31:0]), .in_tag(in_tag),
    .out_valid(out_valid32), .out_ready(out_ready), .out_result(out_result32),
    .out_tag(out_tag32), .busy(busy32));

  mul_pipe #(.XLEN(8), .STAGES(1), .TAG_W(5)) d8 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready8),
    .in_op(in_op), .in_a(in_a[7:0]), .in_b(in_b[7:0]), .in_tag(in_tag),
    .out_valid(out_valid8), .out_ready(out_ready), .out_result(out_result8),
    .out_tag(out_tag8), .busy(busy8));

  mul_pipe #(.XLEN(64), .STAGES(4), .TAG_W(5)) d64 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready64),
    .in_op(in_op), .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .out_valid(out_valid64), .out_ready(out_ready), .out_result(out_result64),
    .out_tag(out_tag64), .busy(busy64));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $display("FAIL %s: observed %h, expected %h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rst_all();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  function automatic int idx(input int k, input int n);
    return (k >= 0 && k < n) ? k : 0;
  endfunction

  // Independent wide reference: exact product of the extended operands.
  function automatic logic [63:0] ref_mul(input int xl, input logic [1:0] op,
                                          input logic [63:0] a, input logic [63:0] b);
    logic [63:0]         mask, am, bm;
    logic signed [129:0] ax, bx, p;
    mask = (xl == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << xl) - 64'd1);
    am = a & mask;
    bm = b & mask;
    ax = $signed({66'd0, am});
    bx = $signed({66'd0, bm});
    if (op != 2'b11 && am[xl-1]) ax = ax - (130'sd1 <<< xl);
    if (!op[1] && bm[xl-1])      bx = bx - (130'sd1 <<< xl);
    p = ax * bx;
    if (op != 2'b00) p = p >>> xl;
    return p[63:0] & mask;
  endfunction

  task automatic set_row(input int i, input logic [1:0] op, input logic [63:0] a,
                         input logic [63:0] b, input logic [4:0] tag, input logic [63:0] x8,
                         input logic [63:0] x32, input logic [63:0] x64);
    op_t[i] = op; a_t[i] = a; b_t[i] = b; tag_t[i] = tag;
    e8[i] = x8; e32[i] = x32; e64[i] = x64;
  endtask

  task automatic chk_out(input string nm, input int k, input int n, input logic v,
                         input logic [63:0] r, input logic [4:0] t,
                         input logic [63:0] er, input logic [4:0] et);
    if (k >= 0 && k < n) begin
      chk({nm, "_valid"}, 64'(v), 64'd1);
      chk({nm, "_result"}, r, er);
      chk({nm, "_tag"}, 64'(t), 64'(et));
    end else begin
      chk({nm, "_idle"}, 64'(v), 64'd0);
    end
  endtask

  // Back-to-back issue with out_ready high; each instance must return
  // row k exactly STAGES-1 edges after its accept, with no gaps.
  task automatic stream(input int n);
    for (int c = 0; c < n + 4; c++) begin
      if (c < n) begin
        in_valid = 1'b1; in_op = op_t[c]; in_a = a_t[c]; in_b = b_t[c]; in_tag = tag_t[c];
      end else begin
        in_valid = 1'b0;
      end
      tick();
      chk_out("d8", c, n, out_valid8, 64'(out_result8), out_tag8,
              e8[idx(c, n)], tag_t[idx(c, n)]);
      chk_out("d32", c - 2, n, out_valid32, 64'(out_result32), out_tag32,
              e32[idx(c - 2, n)], tag_t[idx(c - 2, n)]);
      chk_out("d64", c - 3, n, out_valid64, out_result64, out_tag64,
              e64[idx(c - 3, n)], tag_t[idx(c - 3, n)]);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  i, k;
    bit  acc, seen;
    logic [63:0] ra, rb;
    logic [1:0]  rop;

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_op = 2'b00; in_a = 64'd0; in_b = 64'd0; in_tag = 5'd0;
    rst_all();

    // Reset state
    chk("rst_out_valid", 64'(out_valid32), 64'd0);
    chk("rst_out_result", 64'(out_result32), 64'd0);
    chk("rst_out_tag", 64'(out_tag32), 64'd0);
    chk("rst_busy", 64'(busy32), 64'd0);
    chk("rst_in_ready", 64'(in_ready32), 64'd1);
    chk("rst_in_ready64", 64'(in_ready64), 64'd1);

    // Single MUL 7 * -3, tag 5
    set_row(0, 2'b00, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 5'd5,
            64'hEB, 64'hFFFF_FFEB, 64'hFFFF_FFFF_FFFF_FFEB);
    stream(1);

    // High-half corner table
    set_row(0, 2'b01, 64'hFFFF_FFFF_8000_0000, 64'hFFFF_FFFF_8000_0000, 5'd1,
            64'h0, 64'h4000_0000, 64'h0);
    set_row(1, 2'b11, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd2,
            64'hFE, 64'hFFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFE);
    set_row(2, 2'b10, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd3,
            64'hFF, 64'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
    set_row(3, 2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd4,
            64'h0, 64'h0, 64'h0);
    set_row(4, 2'b01, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 5'd6,
            64'h0, 64'h0, 64'h4000_0000_0000_0000);
    set_row(5, 2'b01, 64'h80, 64'h80, 5'd7, 64'h40, 64'h0, 64'h0);
    stream(6);

    // Eight back-to-back MULs, tags 0..7
    for (int r = 0; r < 8; r++) begin
      set_row(r, 2'b00, 64'(r + 1), 64'd3, 5'(r), 64'(3 * (r + 1)), 64'(3 * (r + 1)),
              64'(3 * (r + 1)));
    end
    stream(8);

    // Backpressure: out_ready low for 5 cycles while issuing 4 ops
    out_ready = 1'b0;
    #1;
    i = 0;
    for (int c = 0; c < 5; c++) begin
      in_valid = (i < 4); in_op = 2'b00; in_a = 64'(10 + i); in_b = 64'd2; in_tag = 5'(10 + i);
      if (c >= 3) chk("stall_in_ready", 64'(in_ready32), 64'd0);
      acc = in_valid && in_ready32;
      tick();
      if (acc) i++;
      if (c >= 2) begin
        chk("stall_valid", 64'(out_valid32), 64'd1);
        chk("stall_result", 64'(out_result32), 64'd20);
        chk("stall_tag", 64'(out_tag32), 64'd10);
      end
    end
    chk("stall_issued", 64'(i), 64'd3);
    out_ready = 1'b1;
    #1;
    k = 0;
    for (int c = 0; c < 20 && k < 4; c++) begin
      if (out_valid32) begin
        chk("drain_result", 64'(out_result32), 64'(20 + 2 * k));
        chk("drain_tag", 64'(out_tag32), 64'(10 + k));
        k++;
      end
      if (i < 4) begin
        in_valid = 1'b1; in_a = 64'(10 + i); in_b = 64'd2; in_tag = 5'(10 + i);
        acc = in_ready32;
      end else begin
        in_valid = 1'b0;
        acc = 1'b0;
      end
      tick();
      if (acc) i++;
    end
    chk("drain_count", 64'(k), 64'd4);

    // Flush with three ops in flight and the output stalled
    rst_all();
    out_ready = 1'b0;
    #1;
    for (int c = 0; c < 3; c++) begin
      in_valid = 1'b1; in_op = 2'b00; in_a = 64'(30 + c); in_b = 64'd1; in_tag = 5'(20 + c);
      chk("flush_fill_ready", 64'(in_ready32), 64'd1);
      tick();
    end
    chk("flush_pre_valid", 64'(out_valid32), 64'd1);
    chk("flush_pre_busy", 64'(busy32), 64'd1);
    flush = 1'b1; in_valid = 1'b1; in_tag = 5'd23;
    #1;
    chk("flush_in_ready", 64'(in_ready32), 64'd0);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_valid", 64'(out_valid32), 64'd0);
    chk("flush_busy", 64'(busy32), 64'd0);
    chk("flush_busy8", 64'(busy8), 64'd0);
    chk("flush_busy64", 64'(busy64), 64'd0);
    out_ready = 1'b1;
    seen = 1'b0;
    repeat (8) begin
      tick();
      if (out_valid32 || out_valid8 || out_valid64) seen = 1'b1;
    end
    chk("flush_no_result", 64'(seen), 64'd0);

    // Reset in the middle of a stream
    rst_all();
    out_ready = 1'b1;
    for (int c = 0; c < 2; c++) begin
      in_valid = 1'b1; in_op = 2'b00; in_a = 64'(5 + c); in_b = 64'd5; in_tag = 5'(25 + c);
      tick();
    end
    rst = 1'b1;
    tick();
    chk("mrst_valid", 64'(out_valid32), 64'd0);
    chk("mrst_result", 64'(out_result32), 64'd0);
    chk("mrst_tag", 64'(out_tag32), 64'd0);
    chk("mrst_busy", 64'(busy32), 64'd0);
    chk("mrst_in_ready", 64'(in_ready32), 64'd1);
    chk("mrst_result8", 64'(out_result8), 64'd0);
    chk("mrst_busy64", 64'(busy64), 64'd0);
    rst = 1'b0; in_valid = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      tick();
      if (out_valid32 || out_valid8 || out_valid64) seen = 1'b1;
    end
    chk("mrst_no_result", 64'(seen), 64'd0);

    // Random signed/unsigned sweep against the wide reference
    for (int r = 0; r < 12; r++) begin
      rop = 2'($urandom_range(3, 0));
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      if (r == 0) begin ra = 64'h8000_0000_0000_0000; rb = 64'h8000_0000_8000_0080; end
      set_row(r, rop, ra, rb, 5'(16 + r), ref_mul(8, rop, ra, rb), ref_mul(32, rop, ra, rb),
              ref_mul(64, rop, ra, rb));
    end
    stream(12);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
